// File: rtl/yarp_wb_pkg.sv
// Shared types and constants for the YARP write-back arbiter slice.
// Used by yarp_wb_if, yarp_rr_arbiter and yarp_wb_arbiter.
package yarp_wb_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REQ_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/yarp_wb_if.sv
// Write-back requester bus: per-requester valid/ready handshake plus rd/data payload.
// The requesters drive the master side, the arbiter sits on the slave side.
interface yarp_wb_if
  import yarp_wb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) ();

  logic    [NUM_REQ-1:0] valid;
  wb_req_t [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] ready;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/yarp_rr_arbiter.sv
// Generic round-robin arbiter: combinational one-hot grant, search starts at the pointer,
// pointer moves just past the winner. Reusable for any shared single-port resource.
module yarp_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         hold,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: every signal written in always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    logic             found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    if (reset_n && !hold) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        idx_w = PTR_W'(idx);
        if (!found && req[idx_w]) begin
          found      = 1'b1;
          gnt[idx_w] = 1'b1;
          ptr_d      = (idx_w == PTR_W'(N - 1)) ? '0 : idx_w + 1'b1;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments and the asynchronous reset in the sensitivity list.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/yarp_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant, one-cycle write stage, x0 filter,
// saturating contention counter. Define YARP_WB_FWD_EN to add the rs1/rs2 write-stage bypass.
module yarp_wb_arbiter
  import yarp_wb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold_i,
  yarp_wb_if.slave              wb,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
  output logic                  rf_wr_en_o,
  output logic [XLEN-1:0]       rf_wr_data_o,
  output logic [CNT_W-1:0]      conflict_cnt_o
`ifdef YARP_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]       rs1_rf_data_i,
  input  logic [XLEN-1:0]       rs2_rf_data_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("yarp_wb_arbiter: NUM_REQ must be in 2..8");
  end

  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  wb_req_t            win;

  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q,   wr_en_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  yarp_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold_i),
    .req     (wb.valid),
    .gnt     (gnt)
  );

  assign wb.ready = gnt;
  // Grants only ever go to valid requesters, so any grant is a transfer.
  assign xfer     = |gnt;

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win = wb.req[i];
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    if (xfer) begin
      // Writes to x0 are accepted from the requester but never reach the regfile.
      wr_en_d   = (win.rd != '0);
      rd_addr_d = win.rd;
      wr_data_d = win.data;
    end
    if (multi_hot(8'(wb.valid)) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rf_rd_addr_o   = rd_addr_q;
  assign rf_wr_en_o     = wr_en_q;
  assign rf_wr_data_o   = wr_data_q;
  assign conflict_cnt_o = cnt_q;

`ifdef YARP_WB_FWD_EN
  // Bypass the write-stage entry to decode while the regfile has not yet committed it.
  assign rs1_data_o = (wr_en_q && rd_addr_q == rs1_addr_i && rs1_addr_i != '0) ? wr_data_q : rs1_rf_data_i;
  assign rs2_data_o = (wr_en_q && rd_addr_q == rs2_addr_i && rs2_addr_i != '0) ? wr_data_q : rs2_rf_data_i;
`endif

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// Directed self-checking bench for yarp_wb_arbiter; a second narrow-counter instance
// exercises contention-counter saturation. Forwarding checks run when YARP_WB_FWD_EN is defined.
module tb_yarp_wb_arbiter;
  import yarp_wb_pkg::*;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;
  localparam logic [31:0] DD = 32'hDDDD_0004;
  localparam logic [31:0] DE = 32'hEEEE_0005;
  localparam logic [31:0] DF = 32'hF0F0_0006;
  localparam logic [31:0] DG = 32'h1357_0007;
  localparam logic [31:0] DH = 32'h2468_0008;

  logic        clk;
  logic        reset_n;
  logic        hold_i;
  logic [4:0]  rf_rd_addr;
  logic        rf_wr_en;
  logic [31:0] rf_wr_data;
  logic [15:0] cnt;

  logic [4:0]  sat_rd_addr;
  logic        sat_wr_en;
  logic [31:0] sat_wr_data;
  logic [3:0]  sat_cnt;

  int errors = 0;
  int checks = 0;

  yarp_wb_if #(.NUM_REQ(3)) bus ();
  yarp_wb_if #(.NUM_REQ(3)) sat_bus ();

`ifdef YARP_WB_FWD_EN
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rf_data, rs2_rf_data, rs1_data, rs2_data;
`endif

  yarp_wb_arbiter #(.NUM_REQ(3), .CNT_W(16)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hold_i         (hold_i),
    .wb             (bus.slave),
    .rf_rd_addr_o   (rf_rd_addr),
    .rf_wr_en_o     (rf_wr_en),
    .rf_wr_data_o   (rf_wr_data),
    .conflict_cnt_o (cnt)
`ifdef YARP_WB_FWD_EN
    ,
    .rs1_addr_i     (rs1_addr),
    .rs2_addr_i     (rs2_addr),
    .rs1_rf_data_i  (rs1_rf_data),
    .rs2_rf_data_i  (rs2_rf_data),
    .rs1_data_o     (rs1_data),
    .rs2_data_o     (rs2_data)
`endif
  );

  yarp_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) u_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .hold_i         (hold_i),
    .wb             (sat_bus.slave),
    .rf_rd_addr_o   (sat_rd_addr),
    .rf_wr_en_o     (sat_wr_en),
    .rf_wr_data_o   (sat_wr_data),
    .conflict_cnt_o (sat_cnt)
`ifdef YARP_WB_FWD_EN
    ,
    .rs1_addr_i     (5'd0),
    .rs2_addr_i     (5'd0),
    .rs1_rf_data_i  (32'd0),
    .rs2_rf_data_i  (32'd0),
    .rs1_data_o     (),
    .rs2_data_o     ()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
    bus.req[i].rd   = rd;
    bus.req[i].data = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_req(0, 5'd5, DA);
    set_req(1, 5'd6, DB);
    set_req(2, 5'd7, DC);
    bus.valid = 3'b111;
    step();
    step();
    checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", bus.ready); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", rf_wr_en); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", cnt); end
    checks++; if (rf_rd_addr !== 5'd0 || rf_wr_data !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h want 0/0", rf_rd_addr, rf_wr_data); end
    reset_n = 1'b1;
    #1;
    checks++; if (bus.ready !== 3'b001) begin errors++; $display("FAIL release_ready: got %b want 001", bus.ready); end
  endtask

  // Continues from test_reset: all three requesters valid with rd 5/6/7.
  task automatic test_round_robin();
    step();
    #1;
    checks++; if (bus.ready !== 3'b010) begin errors++; $display("FAIL rr_c1_ready: got %b want 010", bus.ready); end
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd5 || rf_wr_data !== DA) begin errors++; $display("FAIL rr_c1_write: got %b/%0d/%h want 1/5/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DA); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL rr_c1_cnt: got %0d want 1", cnt); end
    step();
    #1;
    checks++; if (bus.ready !== 3'b100) begin errors++; $display("FAIL rr_c2_ready: got %b want 100", bus.ready); end
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd6 || rf_wr_data !== DB) begin errors++; $display("FAIL rr_c2_write: got %b/%0d/%h want 1/6/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DB); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd7 || rf_wr_data !== DC) begin errors++; $display("FAIL rr_c3_write: got %b/%0d/%h want 1/7/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DC); end
    checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL rr_c3_cnt: got %0d want 3", cnt); end
    checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL rr_idle_ready: got %b want 000", bus.ready); end
    step();
    checks++; if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd7 || rf_wr_data !== DC) begin errors++; $display("FAIL rr_idle_hold: got %b/%0d/%h want 0/7/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DC); end
  endtask

  // Pointer is 0 here.
  task automatic test_x0();
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    bus.valid = 3'b001;
    #1;
    checks++; if (bus.ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b want 001", bus.ready); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en: got %b want 0", rf_wr_en); end
    step();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en_after: got %b want 0", rf_wr_en); end
  endtask

  // Pointer is 1 here.
  task automatic test_hold();
    hold_i = 1'b1;
    set_req(1, 5'd12, DD);
    bus.valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL hold_ready_c%0d: got %b want 000", c, bus.ready); end
      step();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL hold_wr_en_c%0d: got %b want 0", c, rf_wr_en); end
    end
    hold_i = 1'b0;
    #1;
    checks++; if (bus.ready !== 3'b010) begin errors++; $display("FAIL hold_release_ready: got %b want 010", bus.ready); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd12 || rf_wr_data !== DD) begin errors++; $display("FAIL hold_write: got %b/%0d/%h want 1/12/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DD); end
  endtask

  // Pointer is 2 here: requester 2 wins first, requester 0 writes last.
  task automatic test_same_rd();
    set_req(0, 5'd3, DE);
    set_req(2, 5'd3, DF);
    bus.valid = 3'b101;
    #1;
    checks++; if (bus.ready !== 3'b100) begin errors++; $display("FAIL same_rd_first_ready: got %b want 100", bus.ready); end
    step();
    bus.valid = 3'b001;
    #1;
    checks++; if (bus.ready !== 3'b001) begin errors++; $display("FAIL same_rd_second_ready: got %b want 001", bus.ready); end
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd3 || rf_wr_data !== DF) begin errors++; $display("FAIL same_rd_first_write: got %b/%0d/%h want 1/3/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DF); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd3 || rf_wr_data !== DE) begin errors++; $display("FAIL same_rd_final_write: got %b/%0d/%h want 1/3/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DE); end
    checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL same_rd_cnt: got %0d want 4", cnt); end
    step();
  endtask

  // Pointer is 1 here; reset lands before the transfer edge so no write ever appears.
  task automatic test_reset_mid();
    set_req(1, 5'd20, DG);
    bus.valid = 3'b010;
    #1;
    checks++; if (bus.ready !== 3'b010) begin errors++; $display("FAIL mid_pre_ready: got %b want 010", bus.ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL mid_reset_ready: got %b want 000", bus.ready); end
    step();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr_en: got %b want 0", rf_wr_en); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d want 0", cnt); end
    set_req(0, 5'd21, DH);
    bus.valid = 3'b011;
    reset_n = 1'b1;
    #1;
    checks++; if (bus.ready !== 3'b001) begin errors++; $display("FAIL mid_ptr_reset_ready: got %b want 001", bus.ready); end
    step();
    bus.valid = 3'b010;
    #1;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd21 || rf_wr_data !== DH) begin errors++; $display("FAIL mid_write0: got %b/%0d/%h want 1/21/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DH); end
    checks++; if (bus.ready !== 3'b010) begin errors++; $display("FAIL mid_ready1: got %b want 010", bus.ready); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd20 || rf_wr_data !== DG) begin errors++; $display("FAIL mid_write1: got %b/%0d/%h want 1/20/%h", rf_wr_en, rf_rd_addr, rf_wr_data, DG); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt: got %0d want 1", cnt); end
  endtask

  // 4-bit counter instance: 14 contention cycles reach 4'hE, then it sticks at 4'hF.
  task automatic test_saturation();
    sat_bus.valid = 3'b111;
    repeat (14) step();
    checks++; if (sat_cnt !== 4'hE) begin errors++; $display("FAIL sat_pre: got %h want e", sat_cnt); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_c%0d: got %h want f", c, sat_cnt); end
    end
    sat_bus.valid = 3'b000;
  endtask

`ifdef YARP_WB_FWD_EN
  // Pointer is 2 here.
  task automatic test_fwd();
    set_req(2, 5'd9, 32'h0000_1234);
    bus.valid   = 3'b100;
    rs1_addr    = 5'd9;
    rs1_rf_data = 32'd0;
    rs2_addr    = 5'd0;
    rs2_rf_data = 32'h5555_AAAA;
    #1;
    checks++; if (bus.ready !== 3'b100) begin errors++; $display("FAIL fwd_ready: got %b want 100", bus.ready); end
    step();
    bus.valid = 3'b000;
    #1;
    checks++; if (rs1_data !== 32'h0000_1234) begin errors++; $display("FAIL fwd_rs1: got %h want 00001234", rs1_data); end
    checks++; if (rs2_data !== 32'h5555_AAAA) begin errors++; $display("FAIL fwd_rs2_x0: got %h want 5555aaaa", rs2_data); end
    step();
    checks++; if (rs1_data !== 32'd0) begin errors++; $display("FAIL fwd_rs1_idle: got %h want 00000000", rs1_data); end
  endtask
`endif

  initial begin
    hold_i        = 1'b0;
    reset_n       = 1'b0;
    bus.valid     = '0;
    bus.req       = '0;
    sat_bus.valid = '0;
    sat_bus.req   = '0;
`ifdef YARP_WB_FWD_EN
    rs1_addr    = '0;
    rs2_addr    = '0;
    rs1_rf_data = '0;
    rs2_rf_data = '0;
`endif
    test_reset();
    test_round_robin();
    test_x0();
    test_hold();
    test_same_rd();
    test_reset_mid();
    test_saturation();
`ifdef YARP_WB_FWD_EN
    test_fwd();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
